lcd_window_seq: RTL and testbench
=================================

Name: lcd_window_seq

Overview:
Command sequencer that sets up an ST7789 write window and streams pixels into it. On start it issues CASET and RASET with window bounds (plus panel offsets), then RAMWR. It then forwards exactly the window's pixel count of RGB565 words from a pixel source, each as two bytes, high byte first. Output is a byte/DC stream with valid/ready, feeding the SPI byte serializer in front of the LCD pins, in place of scan-synced lcd_video for partial-screen updates.

Parameters:
C_X_SIZE, 240, panel width in pixels; bounds check on x1
C_Y_SIZE, 240, panel height in pixels; bounds check on y1
C_X_OFFSET, 0, added to x0/x1 before transmission
C_Y_OFFSET, 80, added to y0/y1 before transmission
C_COORD_BITS, 8, width of coordinate inputs

Ports:
clk_pixel  in  1  sole clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
x0, x1  in  C_COORD_BITS  inclusive column bounds
y0, y1  in  C_COORD_BITS  inclusive row bounds
pix_data  in  16  RGB565 pixel
pix_valid  in  1  pix_data valid
pix_ready  out  1  pixel accepted when pix_valid&&pix_ready
byte_data  out  8  byte to serializer
byte_dc  out  1  0 = command, 1 = data
byte_valid  out  1  byte_data/byte_dc valid
byte_ready  in  1  serializer accepts when byte_valid&&byte_ready
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last byte handshake
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Interface: one clock, clk_pixel; reset is synchronous and active-high.
- Reset values: byte_valid=0, byte_data=0, byte_dc=0, pix_ready=0, busy=0, done=0, err=0. State is IDLE and counters are 0.
- Reset mid-operation: all outputs return to reset values at the next edge. A partial byte stream is abandoned, and the serializer tolerates byte_valid dropping.
- Output slot: byte_data/byte_dc/byte_valid are registered.
  - The slot loads when empty or when the current byte handshakes in this cycle, so back-to-back bytes at one per cycle are possible.
  - While byte_valid=1 and byte_ready=0, data and DC hold stable.
- Start handling in IDLE:
  - Start is rejected if x0>x1, y0>y1, x1>=C_X_SIZE or y1>=C_Y_SIZE.
  - On reject: err pulses the next cycle and the block stays IDLE.
  - Otherwise: latch bounds, set busy next cycle, compute pix_count=(x1-x0+1)*(y1-y0+1) in 17 bits, and go to CASET.
- Start while busy is ignored, with no err.
- Transmitted coordinates are 16-bit values, sent high then low: X = x+C_X_OFFSET, Y = y+C_Y_OFFSET. Any carry beyond 16 bits is discarded.
- Byte sequence:
  - CASET: cmd 0x2A (dc=0), then data X0h X0l X1h X1l (dc=1).
  - RASET: cmd 0x2B, then data Y0h Y0l Y1h Y1l.
  - RAMWR: cmd 0x2C.
  - PIX_HI/PIX_LO: pixel bytes (dc=1), repeated pix_count times.
- States: IDLE -> CASET_CMD -> CASET_D(0..3) -> RASET_CMD -> RASET_D(0..3) -> RAMWR_CMD -> PIX_HI <-> PIX_LO -> DONE -> IDLE. Each command/data state advances when its byte is loaded into the slot.
- Pixel handshake:
  - pix_ready = (state==PIX_HI) && slot loadable this cycle.
  - On accept, the slot loads pix_data[15:8], pix_data[7:0] is held internally, and the state moves to PIX_LO.
  - PIX_LO loads the held low byte when the slot is loadable and decrements the remaining count. Count reaching 0 goes to DONE, otherwise back to PIX_HI.
  - pix_ready is never high outside PIX_HI, so no pixel is consumed beyond pix_count.
- DONE: waits for the final byte handshake, then pulses done for one cycle and clears busy in that same cycle, then returns to IDLE. A start in the done cycle is ignored; the earliest new start is sampled the following cycle.
- Latency: the first byte (0x2A) is valid on the second edge after the start cycle. Total bytes = 11 + 2*pix_count.

Test Plan:
- 1x1 window at (0,0), byte_ready=1, pix 0xF81F -> bytes 2A,00,00,00,00,2B,00,50,00,50,2C,F8,1F with dc 0,1,1,1,1,0,1,1,1,1,0,1,1. done pulses one cycle after the 13th handshake; pix_ready is high in exactly one accepted cycle.
- Window (10,20)-(12,21), byte_ready toggling 1/0 every cycle, pix_valid random -> 6 pixels, 23 bytes, CASET data 00,0A,00,0C, RASET data 00,64,00,65. Bytes stay stable while stalled, and pixel order is preserved.
- Invalid starts (x0=5,x1=4), (x1=240), (y1=240) -> err pulses one cycle each, busy stays 0, byte_valid stays 0.
- Start pulsed mid-transfer -> ignored with no err; byte count unchanged.
- Reset asserted during PIX_LO with byte_valid=1 -> next edge byte_valid=0, busy=0, pix_ready=0. A new 1x1 start afterwards produces the full sequence again.
- Full frame (0,0)-(239,239) with continuous pix_valid and byte_ready -> 115211 bytes in about 115212 cycles; pix_ready accepts exactly 57600 pixels; done pulses once.

Source files
------------

// File: rtl/lcd_window_seq_if.sv
// ---------------------------------------------------------------------------
// lcd_window_seq_if
//   Stream bundle between the window sequencer, its pixel source and the SPI
//   byte serializer.
//
//   Handshake rule (both streams): a beat transfers on a clock edge where
//   valid && ready are both high. Once valid is raised, the producer holds the
//   payload stable until that transfer. ready may depend combinationally on
//   valid, but valid never depends on ready.
//
//   Signals:
//     pix_data   [15:0]  RGB565 pixel from the source
//     pix_valid          pix_data valid
//     pix_ready          sequencer accepts the pixel
//     byte_data  [7:0]   byte to the serializer
//     byte_dc            0 = command byte, 1 = data byte
//     byte_valid         byte_data/byte_dc valid
//     byte_ready         serializer accepts the byte
//
//   Modports:
//     master  - the sequencer (drives bytes, consumes pixels)
//     slave   - the environment (pixel source + serializer)
// ---------------------------------------------------------------------------
interface lcd_window_seq_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  byte_data;
    logic        byte_dc;
    logic        byte_valid;
    logic        byte_ready;

    modport master (
        input  pix_data, pix_valid, byte_ready,
        output pix_ready, byte_data, byte_dc, byte_valid
    );

    modport slave (
        output pix_data, pix_valid, byte_ready,
        input  pix_ready, byte_data, byte_dc, byte_valid
    );
endinterface

// File: rtl/lcd_window_seq.sv
// ---------------------------------------------------------------------------
// lcd_window_seq
//   ST7789 partial-update sequencer. On an accepted start it emits
//   CASET (0x2A + 4 data bytes), RASET (0x2B + 4 data bytes), RAMWR (0x2C),
//   then streams the window's pixel count of RGB565 words as two data bytes
//   each, high byte first. Coordinates go out as 16-bit values with the panel
//   offsets added.
//
//   Ports:
//     clk_pixel      sole clock
//     reset          synchronous, active-high
//     start          one-cycle request, only looked at in IDLE
//     x0,x1,y0,y1    inclusive window bounds
//     bus            stream bundle (master side): pixel in, byte/DC out
//     busy           high from accepted start until the done cycle
//     done           one-cycle pulse after the last byte handshake
//     err            one-cycle pulse on a rejected start
//     dbg_state_o    current FSM state encoding
// ---------------------------------------------------------------------------
module lcd_window_seq #(
    parameter int C_X_SIZE     = 240,
    parameter int C_Y_SIZE     = 240,
    parameter int C_X_OFFSET   = 0,
    parameter int C_Y_OFFSET   = 80,
    parameter int C_COORD_BITS = 8
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    input  logic                    start,
    input  logic [C_COORD_BITS-1:0] x0,
    input  logic [C_COORD_BITS-1:0] x1,
    input  logic [C_COORD_BITS-1:0] y0,
    input  logic [C_COORD_BITS-1:0] y1,
    lcd_window_seq_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [3:0]              dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CASET_CMD = 4'd1,
        S_CASET_D0  = 4'd2,
        S_CASET_D1  = 4'd3,
        S_CASET_D2  = 4'd4,
        S_CASET_D3  = 4'd5,
        S_RASET_CMD = 4'd6,
        S_RASET_D0  = 4'd7,
        S_RASET_D1  = 4'd8,
        S_RASET_D2  = 4'd9,
        S_RASET_D3  = 4'd10,
        S_RAMWR_CMD = 4'd11,
        S_PIX_HI    = 4'd12,
        S_PIX_LO    = 4'd13,
        S_DONE      = 4'd14
    } state_t;

    localparam logic [31:0] X_LIM = 32'(C_X_SIZE);
    localparam logic [31:0] Y_LIM = 32'(C_Y_SIZE);
    localparam logic [15:0] X_OFF = 16'(C_X_OFFSET);
    localparam logic [15:0] Y_OFF = 16'(C_Y_OFFSET);

    state_t      state_q, state_d;
    logic [15:0] xs0_q, xs0_d, xs1_q, xs1_d;
    logic [15:0] ys0_q, ys0_d, ys1_q, ys1_d;
    logic [16:0] count_q, count_d;
    logic [7:0]  lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  byte_data_q;
    logic        byte_dc_q;
    logic        byte_valid_q;

    logic        slot_free;
    logic        slot_load;
    logic [7:0]  slot_data;
    logic        slot_dc;
    logic        pix_rdy;
    logic        bad_window;
    logic [16:0] dx, dy, pix_count_c;

    // The output slot can take a new byte when it is empty or when its
    // current byte leaves this cycle.
    assign slot_free   = !byte_valid_q || bus.byte_ready;

    assign bad_window  = (x0 > x1) || (y0 > y1) ||
                         (32'(x1) >= X_LIM) || (32'(y1) >= Y_LIM);
    assign dx          = 17'(x1) - 17'(x0) + 17'd1;
    assign dy          = 17'(y1) - 17'(y0) + 17'd1;
    assign pix_count_c = dx * dy;

    always_comb begin
        state_d   = state_q;
        xs0_d     = xs0_q;
        xs1_d     = xs1_q;
        ys0_d     = ys0_q;
        ys1_d     = ys1_q;
        count_d   = count_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        slot_load = 1'b0;
        slot_data = 8'h00;
        slot_dc   = 1'b1;
        pix_rdy   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The done cycle shows IDLE but still refuses a new start.
                if (start && !done_q) begin
                    if (bad_window) begin
                        err_d = 1'b1;
                    end else begin
                        xs0_d   = 16'(x0) + X_OFF;
                        xs1_d   = 16'(x1) + X_OFF;
                        ys0_d   = 16'(y0) + Y_OFF;
                        ys1_d   = 16'(y1) + Y_OFF;
                        count_d = pix_count_c;
                        busy_d  = 1'b1;
                        state_d = S_CASET_CMD;
                    end
                end
            end
            S_CASET_CMD: if (slot_free) begin
                slot_load = 1'b1; slot_dc = 1'b0; slot_data = 8'h2A; state_d = S_CASET_D0;
            end
            S_CASET_D0: if (slot_free) begin
                slot_load = 1'b1; slot_data = xs0_q[15:8]; state_d = S_CASET_D1;
            end
            S_CASET_D1: if (slot_free) begin
                slot_load = 1'b1; slot_data = xs0_q[7:0]; state_d = S_CASET_D2;
            end
            S_CASET_D2: if (slot_free) begin
                slot_load = 1'b1; slot_data = xs1_q[15:8]; state_d = S_CASET_D3;
            end
            S_CASET_D3: if (slot_free) begin
                slot_load = 1'b1; slot_data = xs1_q[7:0]; state_d = S_RASET_CMD;
            end
            S_RASET_CMD: if (slot_free) begin
                slot_load = 1'b1; slot_dc = 1'b0; slot_data = 8'h2B; state_d = S_RASET_D0;
            end
            S_RASET_D0: if (slot_free) begin
                slot_load = 1'b1; slot_data = ys0_q[15:8]; state_d = S_RASET_D1;
            end
            S_RASET_D1: if (slot_free) begin
                slot_load = 1'b1; slot_data = ys0_q[7:0]; state_d = S_RASET_D2;
            end
            S_RASET_D2: if (slot_free) begin
                slot_load = 1'b1; slot_data = ys1_q[15:8]; state_d = S_RASET_D3;
            end
            S_RASET_D3: if (slot_free) begin
                slot_load = 1'b1; slot_data = ys1_q[7:0]; state_d = S_RAMWR_CMD;
            end
            S_RAMWR_CMD: if (slot_free) begin
                slot_load = 1'b1; slot_dc = 1'b0; slot_data = 8'h2C; state_d = S_PIX_HI;
            end
            S_PIX_HI: begin
                // Only here is a pixel ever consumed, so the source is never
                // drained past the window's pixel count.
                pix_rdy = slot_free;
                if (slot_free && bus.pix_valid) begin
                    slot_load = 1'b1;
                    slot_data = bus.pix_data[15:8];
                    lo_d      = bus.pix_data[7:0];
                    state_d   = S_PIX_LO;
                end
            end
            S_PIX_LO: if (slot_free) begin
                slot_load = 1'b1;
                slot_data = lo_q;
                count_d   = count_q - 17'd1;
                state_d   = (count_q == 17'd1) ? S_DONE : S_PIX_HI;
            end
            S_DONE: begin
                // slot_free here means the final byte is gone or leaves now.
                if (slot_free) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q      <= S_IDLE;
            xs0_q        <= '0;
            xs1_q        <= '0;
            ys0_q        <= '0;
            ys1_q        <= '0;
            count_q      <= '0;
            lo_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            byte_data_q  <= '0;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xs0_q   <= xs0_d;
            xs1_q   <= xs1_d;
            ys0_q   <= ys0_d;
            ys1_q   <= ys1_d;
            count_q <= count_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (slot_load) begin
                byte_data_q  <= slot_data;
                byte_dc_q    <= slot_dc;
                byte_valid_q <= 1'b1;
            end else if (bus.byte_ready) begin
                byte_valid_q <= 1'b0;
            end
        end
    end

    assign bus.byte_data  = byte_data_q;
    assign bus.byte_dc    = byte_dc_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.pix_ready  = pix_rdy;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_lcd_window_seq.sv
// ---------------------------------------------------------------------------
// tb_lcd_window_seq
//   Directed bench for lcd_window_seq: expected byte/DC words are queued when
//   a window and its pixels are set up, and popped by a monitor on every byte
//   handshake.
// ---------------------------------------------------------------------------
module tb_lcd_window_seq;
    localparam int X_OFF = 0;
    localparam int Y_OFF = 80;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0, x1, y0, y1;
    logic       busy, done, err;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    lcd_window_seq_if bus ();

    lcd_window_seq #(
        .C_X_SIZE(240), .C_Y_SIZE(240), .C_X_OFFSET(X_OFF),
        .C_Y_OFFSET(Y_OFF), .C_COORD_BITS(8)
    ) dut (
        .clk_pixel(clk), .reset(reset), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .bus(bus), .busy(busy), .done(done), .err(err),
        .dbg_state_o(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int byte_cnt = 0;
    int pix_acc_cnt = 0;
    int pix_rdy_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_hs_cyc = -1;
    int ready_mode = 0;     // 0: always ready, 1: toggle, 2: random
    bit pix_rand = 1'b0;

    logic [8:0]  exp_q[$];
    logic [15:0] src_q[$];
    logic [8:0]  mon_exp;
    bit          stall_prev = 1'b0;
    logic [9:0]  stall_val;

    logic [8:0] t1 [13] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100,
                            9'h02B, 9'h100, 9'h150, 9'h100, 9'h150,
                            9'h02C, 9'h1F8, 9'h11F};

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (stall_prev) begin
            checks++;
            assert ({bus.byte_valid, bus.byte_dc, bus.byte_data} === stall_val) else begin
                errors++;
                $error("FAIL stall_hold got %h expected %h", {bus.byte_valid, bus.byte_dc, bus.byte_data}, stall_val);
            end
        end
        if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
            byte_cnt++;
            last_hs_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL byte_unexpected got %h expected none", {bus.byte_dc, bus.byte_data});
            end else begin
                mon_exp = exp_q.pop_front();
                assert ({bus.byte_dc, bus.byte_data} === mon_exp) else begin
                    errors++;
                    $error("FAIL byte_seq[%0d] got %h expected %h", byte_cnt, {bus.byte_dc, bus.byte_data}, mon_exp);
                end
            end
        end
        stall_prev = (bus.byte_valid === 1'b1) && (bus.byte_ready === 1'b0);
        stall_val  = {1'b1, bus.byte_dc, bus.byte_data};
        if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) pix_acc_cnt++;
        if (bus.pix_ready === 1'b1) pix_rdy_cyc++;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    // ---------------- drivers ----------------
    initial begin
        bus.byte_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.byte_ready = 1'b1;
                1:       bus.byte_ready = ~bus.byte_ready;
                default: bus.byte_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        bit acc;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 16'h0000;
        forever begin
            @(negedge clk);
            acc = (bus.pix_valid === 1'b1) && (bus.pix_ready === 1'b1);
            @(posedge clk); #1;
            if (acc && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                bus.pix_data  = src_q[0];
                bus.pix_valid = pix_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                bus.pix_valid = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic dc, input logic [7:0] d);
        exp_q.push_back({dc, d});
    endtask

    task automatic push_header(input logic [7:0] a0, a1, b0, b1);
        logic [15:0] xa, xb, ya, yb;
        xa = 16'(a0) + 16'(X_OFF);
        xb = 16'(a1) + 16'(X_OFF);
        ya = 16'(b0) + 16'(Y_OFF);
        yb = 16'(b1) + 16'(Y_OFF);
        push_exp(1'b0, 8'h2A);
        push_exp(1'b1, xa[15:8]); push_exp(1'b1, xa[7:0]);
        push_exp(1'b1, xb[15:8]); push_exp(1'b1, xb[7:0]);
        push_exp(1'b0, 8'h2B);
        push_exp(1'b1, ya[15:8]); push_exp(1'b1, ya[7:0]);
        push_exp(1'b1, yb[15:8]); push_exp(1'b1, yb[7:0]);
        push_exp(1'b0, 8'h2C);
    endtask

    task automatic push_pixels(input int n);
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            p = 16'($urandom_range(0, 65535));
            src_q.push_back(p);
            push_exp(1'b1, p[15:8]);
            push_exp(1'b1, p[7:0]);
        end
    endtask

    task automatic pulse_start(input logic [7:0] a0, a1, b0, b1);
        @(posedge clk); #1;
        x0 = a0; x1 = a1; y0 = b0; y1 = b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    // Start the window (expectations already queued) and check its outcome.
    task automatic run_and_check(input logic [7:0] a0, a1, b0, b1, input int n, input bit mid);
        int bc0, pc0, dc0, ec0;
        bc0 = byte_cnt; pc0 = pix_acc_cnt; dc0 = done_cnt; ec0 = err_cnt;
        pulse_start(a0, a1, b0, b1);
        @(negedge clk);
        check("valid_one_edge_after_start", 32'(bus.byte_valid), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        @(negedge clk);
        check("first_byte_valid", 32'(bus.byte_valid), 32'd1);
        check("first_byte_caset", 32'({bus.byte_dc, bus.byte_data}), 32'h02A);
        if (mid) begin
            repeat (10) @(posedge clk);
            pulse_start(8'd0, 8'd0, 8'd0, 8'd0);
        end
        wait_done(60 + 4 * (11 + 2 * n));
        check("done_one_after_last_byte", 32'(cyc), 32'(last_hs_cyc + 1));
        check("busy_clear_with_done", 32'(busy), 32'd0);
        check("byte_count", 32'(byte_cnt - bc0), 32'(11 + 2 * n));
        check("pixel_count", 32'(pix_acc_cnt - pc0), 32'(n));
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("no_err_pulse", 32'(err_cnt - ec0), 32'd0);
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'd0);
        check("done_pulse_count", 32'(done_cnt - dc0), 32'd1);
    endtask

    task automatic test_1x1();
        int rc0;
        ready_mode = 0; pix_rand = 1'b0;
        foreach (t1[i]) exp_q.push_back(t1[i]);
        src_q.push_back(16'hF81F);
        rc0 = pix_rdy_cyc;
        run_and_check(8'd0, 8'd0, 8'd0, 8'd0, 1, 1'b0);
        check("pix_ready_cycles_1x1", 32'(pix_rdy_cyc - rc0), 32'd1);
    endtask

    task automatic bad_start(input logic [7:0] a0, a1, b0, b1, input string tag);
        pulse_start(a0, a1, b0, b1);
        @(negedge clk);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(bus.byte_valid), 32'd0);
        @(negedge clk);
        check({tag, "_err_once"}, 32'(err), 32'd0);
        check({tag, "_idle"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.byte_valid), 32'd0);
        check("rst_data", 32'(bus.byte_data), 32'd0);
        check("rst_dc", 32'(bus.byte_dc), 32'd0);
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;

        // 1x1 window at the origin
        test_1x1();

        // 3x2 window, serializer toggling, bursty pixel source
        ready_mode = 1; pix_rand = 1'b1;
        push_header(8'd10, 8'd12, 8'd20, 8'd21);
        push_pixels(6);
        run_and_check(8'd10, 8'd12, 8'd20, 8'd21, 6, 1'b0);

        // rejected starts
        ready_mode = 0; pix_rand = 1'b0;
        bad_start(8'd5, 8'd4, 8'd0, 8'd0, "bad_x_order");
        bad_start(8'd0, 8'd240, 8'd0, 8'd0, "bad_x1_range");
        bad_start(8'd0, 8'd0, 8'd0, 8'd240, "bad_y1_range");

        // start pulsed while busy is ignored
        push_header(8'd1, 8'd4, 8'd2, 8'd3);
        push_pixels(8);
        run_and_check(8'd1, 8'd4, 8'd2, 8'd3, 8, 1'b1);

        // window touching the far panel corner, random stalls on both sides
        ready_mode = 2; pix_rand = 1'b1;
        push_header(8'd236, 8'd239, 8'd237, 8'd239);
        push_pixels(12);
        run_and_check(8'd236, 8'd239, 8'd237, 8'd239, 12, 1'b0);

        // reset while a low pixel byte is pending
        ready_mode = 0; pix_rand = 1'b0;
        push_header(8'd0, 8'd1, 8'd0, 8'd1);
        push_pixels(4);
        pulse_start(8'd0, 8'd1, 8'd0, 8'd1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dbg_state == 4'd13 && bus.byte_valid === 1'b1) break;
        end
        check("reached_pix_lo", 32'(dbg_state), 32'd13);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.byte_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        src_q.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        test_1x1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
